// File: rtl/rv_mem_arb.sv
// rv_mem_arb: RV32 instruction/data memory with host peripheral access.
//
// Main RAM (Nk kB) is dual-ported. Port A is instruction fetch only. Port B is
// shared by the CPU data bus (d_*) and the host peripheral bus (p_*). Access to
// port B is arbitrated: the CPU normally has priority, and a starvation counter
// forces a waiting host request through after STARVE denied cycles.
// A separate true-dual-port mailbox (SHM_WORDS words at SHM_BASE) sits beside
// the RAM. Its top two words act as doorbells that drive irq_cpu / irq_host.
//
// Ports:
//   clk, xreset           clock, asynchronous active-low reset
//   rdy                   CPU pipeline advance enable (gates i_* and d_*)
//   i_adr/i_re/i_dr       instruction fetch, data valid the cycle after fetch
//   d_adr/d_dw/d_we/d_re  CPU data access, d_dr valid the cycle after accept
//   d_wait                data access refused this cycle, CPU holds request
//   p_adr/p_dw/p_we/p_re  host request, held stable until p_ack
//   p_dr/p_ack            one-cycle completion pulse with read data
//   irq_cpu/irq_host      doorbell levels (host->CPU, CPU->host)
module rv_mem_arb #(
    parameter int          Nk        = 32,
    parameter int          SHM_WORDS = 64,
    parameter logic [31:0] SHM_BASE  = 32'h0010_0000,
    parameter int          STARVE    = 8
) (
    input  logic        clk,
    input  logic        xreset,
    input  logic        rdy,
    input  logic [31:0] i_adr,
    output logic [31:0] i_dr,
    input  logic        i_re,
    input  logic [31:0] d_adr,
    input  logic [31:0] d_dw,
    output logic [31:0] d_dr,
    input  logic [3:0]  d_we,
    input  logic        d_re,
    output logic        d_wait,
    input  logic [31:0] p_adr,
    input  logic [31:0] p_dw,
    output logic [31:0] p_dr,
    input  logic        p_we,
    input  logic        p_re,
    output logic        p_ack,
    output logic        irq_cpu,
    output logic        irq_host
);
    localparam int          Nb        = $clog2(Nk) + 10;
    localparam int          RAM_WORDS = Nk * 256;
    localparam int          SW        = $clog2(SHM_WORDS);
    localparam logic [31:0] SHM_END   = SHM_BASE + 32'(4 * SHM_WORDS);
    localparam logic [SW-1:0] H2C     = SW'(SHM_WORDS - 2);
    localparam logic [SW-1:0] C2H     = SW'(SHM_WORDS - 1);
    localparam logic [7:0]  STARVE_C  = 8'(STARVE);

    logic [31:0] ram [RAM_WORDS];
    logic [31:0] shm [SHM_WORDS];

    // Decode. The mailbox takes precedence should it ever be placed inside RAM.
    logic d_shm, p_shm, d_ram, p_ram, i_ram;
    assign d_shm = (d_adr >= SHM_BASE) && (d_adr < SHM_END);
    assign p_shm = (p_adr >= SHM_BASE) && (p_adr < SHM_END);
    assign d_ram = (d_adr[31:Nb] == '0) && !d_shm;
    assign p_ram = (p_adr[31:Nb] == '0) && !p_shm;
    assign i_ram = (i_adr[31:Nb] == '0);

    // Fetches are word aligned; the byte offset carries no information.
    logic unused_i_lsb;
    assign unused_i_lsb = ^i_adr[1:0];

    logic [Nb-3:0] d_ridx, p_ridx, i_ridx, b_idx;
    logic [SW-1:0] d_sidx, p_sidx;
    assign d_ridx = d_adr[Nb-1:2];
    assign p_ridx = p_adr[Nb-1:2];
    assign i_ridx = i_adr[Nb-1:2];
    assign d_sidx = d_adr[SW+1:2];
    assign p_sidx = p_adr[SW+1:2];

    logic [7:0]  starve_q, starve_d;
    logic        p_ack_q, irq_cpu_q, irq_cpu_d, irq_host_q, irq_host_d, i_re_q;
    logic [1:0]  d_src_q, d_src_d, p_src_q, p_src_d;   // {mailbox, ram} read valid
    logic [31:0] b_q, i_q, d_shm_q, p_shm_q;

    logic d_req, d_ram_req, p_req, p_ram_req, force_gnt;
    logic d_acc, d_ram_acc, d_shm_acc, p_grant, p_ram_gnt, p_shm_gnt;

    assign d_req     = d_re | (|d_we);
    assign d_ram_req = rdy & d_req & d_ram;
    // No new grant in the ack cycle: the host is still holding its request.
    assign p_req     = (p_re | p_we) & !p_ack_q;
    assign p_ram_req = p_req & p_ram;
    assign force_gnt = (starve_q == STARVE_C) & p_ram_req;

    assign d_wait    = force_gnt & d_ram_req;
    assign d_acc     = rdy & d_req & !d_wait;
    assign d_ram_acc = d_acc & d_ram;
    assign d_shm_acc = d_acc & d_shm;

    // Mailbox and unmapped requests never conflict; only a RAM/RAM clash denies.
    assign p_grant   = p_req & !(p_ram & d_ram_acc);
    assign p_ram_gnt = p_grant & p_ram;
    assign p_shm_gnt = p_grant & p_shm;

    assign b_idx = d_ram_acc ? d_ridx : p_ridx;

    always_comb begin
        starve_d   = starve_q;
        d_src_d    = {d_acc & d_re & d_shm, d_acc & d_re & d_ram};
        p_src_d    = {p_shm_gnt & p_re, p_ram_gnt & p_re};
        // A withdrawn request must not leave a stale count behind.
        if (!p_ram_req || p_grant) starve_d = '0;
        else if (starve_q != STARVE_C) starve_d = starve_q + 8'd1;
        // Set wins over clear when both land in the same cycle.
        irq_cpu_d  = (p_shm_gnt & p_we & (p_sidx == H2C)) |
                     (irq_cpu_q & !(d_shm_acc & (|d_we) & (d_sidx == H2C)));
        irq_host_d = (d_shm_acc & (|d_we) & (d_sidx == C2H)) |
                     (irq_host_q & !(p_shm_gnt & p_we & (p_sidx == C2H)));
    end

    always_ff @(posedge clk or negedge xreset) begin
        if (!xreset) begin
            starve_q   <= '0;
            p_ack_q    <= 1'b0;
            irq_cpu_q  <= 1'b0;
            irq_host_q <= 1'b0;
            i_re_q     <= 1'b0;
            d_src_q    <= '0;
            p_src_q    <= '0;
        end else begin
            starve_q   <= starve_d;
            p_ack_q    <= p_grant;
            irq_cpu_q  <= irq_cpu_d;
            irq_host_q <= irq_host_d;
            d_src_q    <= d_src_d;
            p_src_q    <= p_src_d;
            if (rdy) i_re_q <= i_re & i_ram;
        end
    end

    // Main RAM: port A read-only fetch, port B read/write for d or p.
    always_ff @(posedge clk) begin
        if (d_ram_acc) begin
            for (int b = 0; b < 4; b++)
                if (d_we[b]) ram[d_ridx][8*b +: 8] <= d_dw[8*b +: 8];
        end else if (p_ram_gnt && p_we) begin
            ram[p_ridx] <= p_dw;
        end
        b_q <= ram[b_idx];
        if (rdy) i_q <= ram[i_ridx];
    end

    // Mailbox: the d write is issued last so it wins a same-word collision.
    always_ff @(posedge clk) begin
        if (p_shm_gnt && p_we) shm[p_sidx] <= p_dw;
        if (d_shm_acc) begin
            for (int b = 0; b < 4; b++)
                if (d_we[b]) shm[d_sidx][8*b +: 8] <= d_dw[8*b +: 8];
        end
        d_shm_q <= shm[d_sidx];
        p_shm_q <= shm[p_sidx];
    end

    assign i_dr     = i_re_q ? i_q : '0;
    assign d_dr     = d_src_q[0] ? b_q : (d_src_q[1] ? d_shm_q : '0);
    assign p_dr     = p_src_q[0] ? b_q : (p_src_q[1] ? p_shm_q : '0);
    assign p_ack    = p_ack_q;
    assign irq_cpu  = irq_cpu_q;
    assign irq_host = irq_host_q;
endmodule

// File: tb/tb_rv_mem_arb.sv
module tb_rv_mem_arb;
    localparam logic [31:0] H2C = 32'h0010_00F8;
    localparam logic [31:0] C2H = 32'h0010_00FC;

    logic        clk, xreset, rdy;
    logic [31:0] i_adr, i_dr, d_adr, d_dw, d_dr, p_adr, p_dw, p_dr;
    logic [3:0]  d_we;
    logic        i_re, d_re, d_wait, p_we, p_re, p_ack, irq_cpu, irq_host;
    int          n_chk, n_err;

    rv_mem_arb dut (
        .clk(clk), .xreset(xreset), .rdy(rdy),
        .i_adr(i_adr), .i_dr(i_dr), .i_re(i_re),
        .d_adr(d_adr), .d_dw(d_dw), .d_dr(d_dr), .d_we(d_we), .d_re(d_re), .d_wait(d_wait),
        .p_adr(p_adr), .p_dw(p_dw), .p_dr(p_dr), .p_we(p_we), .p_re(p_re), .p_ack(p_ack),
        .irq_cpu(irq_cpu), .irq_host(irq_host)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_i_dr"}, i_dr, 32'h0);
        chk({tag, "_d_dr"}, d_dr, 32'h0);
        chk({tag, "_p_dr"}, p_dr, 32'h0);
        chk({tag, "_flags"}, {27'h0, p_ack, d_wait, irq_cpu, irq_host, 1'b0}, 32'h0);
    endtask

    initial begin
        n_chk = 0; n_err = 0;
        xreset = 1'b1; rdy = 1'b1;
        i_adr = '0; i_re = 1'b0;
        d_adr = '0; d_dw = '0; d_we = '0; d_re = 1'b0;
        p_adr = '0; p_dw = '0; p_we = 1'b0; p_re = 1'b0;
        #1 xreset = 1'b0;
        #1 chk_all_zero("reset");
        tick(); tick();
        @(negedge clk) xreset = 1'b1;
        tick();

        // Basic d write/read and instruction fetch.
        d_adr = 32'h40; d_dw = 32'hDEADBEEF; d_we = 4'hF;
        tick();
        d_we = 4'h0; d_re = 1'b1; i_re = 1'b1; i_adr = 32'h40;
        tick();
        chk("d_read", d_dr, 32'hDEADBEEF);
        chk("i_fetch", i_dr, 32'hDEADBEEF);
        d_re = 1'b0; i_re = 1'b0;
        tick();
        chk("d_idle", d_dr, 32'h0);
        chk("i_idle", i_dr, 32'h0);

        // Host read with idle d bus: grant this cycle, ack next.
        p_re = 1'b1; p_adr = 32'h40;
        @(negedge clk) chk("p_pre_ack", {31'h0, p_ack}, 32'h0);
        tick();
        chk("p_ack", {31'h0, p_ack}, 32'h1);
        chk("p_dr", p_dr, 32'hDEADBEEF);
        p_re = 1'b0;
        tick();
        chk("p_ack_pulse", {31'h0, p_ack}, 32'h0);
        chk("p_dr_idle", p_dr, 32'h0);
        p_re = 1'b1; p_adr = 32'h0800_0000;
        tick();
        chk("p_unmap_ack", {31'h0, p_ack}, 32'h1);
        chk("p_unmap_dr", p_dr, 32'h0);
        p_re = 1'b0;
        tick();

        // Starvation: d reads RAM every cycle while a host write waits.
        d_re = 1'b1; d_adr = 32'h40;
        p_we = 1'b1; p_adr = 32'h44; p_dw = 32'h12345678;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk) chk("starve_nowait", {31'h0, d_wait}, 32'h0);
            tick();
            chk("starve_noack", {31'h0, p_ack}, 32'h0);
        end
        @(negedge clk) chk("starve_wait", {31'h0, d_wait}, 32'h1);
        tick();
        chk("starve_ack", {31'h0, p_ack}, 32'h1);
        chk("starve_d_dropped", d_dr, 32'h0);
        chk("starve_wait_clr", {31'h0, d_wait}, 32'h0);
        p_we = 1'b0;
        tick();
        chk("starve_reissue", d_dr, 32'hDEADBEEF);
        d_adr = 32'h44;
        tick();
        chk("starve_p_data", d_dr, 32'h12345678);
        d_re = 1'b0;
        tick();

        // Doorbells.
        p_we = 1'b1; p_adr = H2C; p_dw = 32'hA5A5A5A5;
        tick();
        chk("h2c_set", {31'h0, irq_cpu}, 32'h1);
        p_we = 1'b0;
        tick();
        d_we = 4'h1; d_adr = H2C; d_dw = 32'h0000003C;
        tick();
        chk("h2c_clr", {31'h0, irq_cpu}, 32'h0);
        d_we = 4'hF; d_adr = C2H; d_dw = 32'hCAFEF00D;
        p_we = 1'b1; p_adr = C2H; p_dw = 32'h11111111;
        tick();
        chk("c2h_set_wins", {31'h0, irq_host}, 32'h1);
        chk("c2h_p_ack", {31'h0, p_ack}, 32'h1);
        d_we = 4'h0; p_we = 1'b0;
        tick();
        d_re = 1'b1; d_adr = C2H; p_re = 1'b1; p_adr = H2C;
        tick();
        chk("c2h_d_wins", d_dr, 32'hCAFEF00D);
        chk("h2c_bytes", p_dr, 32'hA5A5A53C);
        chk("c2h_hold", {31'h0, irq_host}, 32'h1);
        d_re = 1'b0; p_re = 1'b0;
        tick();
        d_we = 4'hF; d_adr = H2C; d_dw = 32'h0BADF00D;
        p_we = 1'b1; p_adr = H2C; p_dw = 32'h22222222;
        tick();
        chk("h2c_set_wins", {31'h0, irq_cpu}, 32'h1);
        d_we = 4'h0; p_we = 1'b0;
        tick();

        // rdy = 0 blocks d writes but not the host.
        d_we = 4'hF; d_adr = 32'h80; d_dw = 32'h55667788;
        tick();
        d_we = 4'h0; i_re = 1'b1; i_adr = 32'h40;
        tick();
        chk("i_fetch2", i_dr, 32'hDEADBEEF);
        rdy = 1'b0; i_re = 1'b0; d_we = 4'h3; d_dw = 32'hFFFFFFFF;
        @(negedge clk) chk("rdy0_nowait", {31'h0, d_wait}, 32'h0);
        tick();
        chk("i_hold", i_dr, 32'hDEADBEEF);
        rdy = 1'b1; d_we = 4'h0; d_re = 1'b1;
        tick();
        chk("rdy0_no_write", d_dr, 32'h55667788);
        rdy = 1'b0; d_re = 1'b0; d_we = 4'h3;
        p_we = 1'b1; p_adr = 32'h80; p_dw = 32'h99AABBCC;
        tick();
        chk("rdy0_p_ack", {31'h0, p_ack}, 32'h1);
        p_we = 1'b0; rdy = 1'b1; d_we = 4'h0; d_re = 1'b1;
        tick();
        chk("rdy0_p_data", d_dr, 32'h99AABBCC);

        // Reset mid-transaction: no ack, outputs cleared asynchronously.
        i_re = 1'b1; i_adr = 32'h40; d_adr = 32'h40;
        tick();
        chk("pre_rst_i", i_dr, 32'hDEADBEEF);
        d_adr = C2H; p_re = 1'b1; p_adr = 32'h40;
        @(negedge clk);
        chk("rst_grant_cycle", {31'h0, p_ack}, 32'h0);
        xreset = 1'b0;
        #1 chk_all_zero("async_rst");
        tick();
        chk("rst_no_ack", {31'h0, p_ack}, 32'h0);
        p_re = 1'b0; d_re = 1'b0; i_re = 1'b0;
        @(negedge clk) xreset = 1'b1;
        tick();
        chk("post_rst_no_ack", {31'h0, p_ack}, 32'h0);
        chk("post_rst_irq", {30'h0, irq_cpu, irq_host}, 32'h0);
        d_re = 1'b1; d_adr = 32'h40;
        tick();
        chk("ram_kept", d_dr, 32'hDEADBEEF);
        d_re = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
